// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between byte requesters, the arbiter and the UART transmitter.
// slave = arbiter side, master = requester/transmitter side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int B_PER_T = 8
);
  logic [NUM_REQ*B_PER_T-1:0] i_req_data;
  logic [NUM_REQ-1:0]         i_req_valid;
  logic [NUM_REQ-1:0]         o_req_ready;
  logic [NUM_REQ-1:0]         o_grant;
  logic [B_PER_T-1:0]         o_tx_data;
  logic                       o_tx_dv;
  logic                       i_tx_done;
  logic                       o_busy;

  modport slave (
    input  i_req_data, i_req_valid, i_tx_done,
    output o_req_ready, o_grant, o_tx_data, o_tx_dv, o_busy
  );

  modport master (
    output i_req_data, i_req_valid, i_tx_done,
    input  o_req_ready, o_grant, o_tx_data, o_tx_dv, o_busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte sources,
// with bursts of up to MAX_BURST bytes per grant.
//
// state | meaning
// IDLE  | arbitrate; accept the winner's byte
// SEND  | tx_dv strobe to the transmitter
// WAIT  | wait for tx_done; continue burst or release grant
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int B_PER_T   = 8,
  parameter int MAX_BURST = 4
) (
  input logic              i_clk,
  input logic              i_rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int BC_W  = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [B_PER_T-1:0]   tx_data_q, tx_data_d;
  logic                 tx_dv_q, tx_dv_d;
  logic [BC_W-1:0]      burst_q, burst_d;

  logic [NUM_REQ-1:0]   ready_c;
  logic [IDX_W-1:0]     win_idx;
  logic                 win_found;
  logic                 owner_cont;
  logic [B_PER_T-1:0]   req_bytes [NUM_REQ];

  function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = (int'(base) + 1 + off) % NUM_REQ;
    return IDX_W'(s);
  endfunction

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      req_bytes[k] = bus.i_req_data[k*B_PER_T +: B_PER_T];
    end
  end

  // Search starts just after the previous owner so every source gets a turn.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && bus.i_req_valid[rr_idx(last_q, i)]) begin
        win_found = 1'b1;
        win_idx   = rr_idx(last_q, i);
      end
    end
  end

  assign owner_cont = bus.i_req_valid[owner_q] && (burst_q < BC_W'(MAX_BURST));

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    owner_d   = owner_q;
    grant_d   = grant_q;
    tx_data_d = tx_data_q;
    tx_dv_d   = 1'b0;
    burst_d   = burst_q;
    ready_c   = '0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          ready_c[win_idx] = 1'b1;
          tx_data_d        = req_bytes[win_idx];
          owner_d          = win_idx;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          burst_d          = BC_W'(1);
          tx_dv_d          = 1'b1;
          state_d          = SEND;
        end
      end
      SEND: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.i_tx_done) begin
          if (owner_cont) begin
            ready_c[owner_q] = 1'b1;
            tx_data_d        = req_bytes[owner_q];
            burst_d          = burst_q + BC_W'(1);
            tx_dv_d          = 1'b1;
            state_d          = SEND;
          end else begin
            last_d  = owner_q;
            grant_d = '0;
            burst_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // No byte may be accepted while reset is held.
    if (i_rst) begin
      ready_c = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      last_q    <= IDX_W'(NUM_REQ - 1);
      owner_q   <= '0;
      grant_q   <= '0;
      tx_data_q <= '0;
      tx_dv_q   <= 1'b0;
      burst_q   <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      grant_q   <= grant_d;
      tx_data_q <= tx_data_d;
      tx_dv_q   <= tx_dv_d;
      burst_q   <= burst_d;
    end
  end

  assign bus.o_req_ready = ready_c;
  assign bus.o_grant     = grant_q;
  assign bus.o_tx_data   = tx_data_q;
  assign bus.o_tx_dv     = tx_dv_q;
  assign bus.o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: one instance with MAX_BURST=4, one with MAX_BURST=1.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(4), .B_PER_T(8)) bus4 ();
  uart_tx_arbiter_if #(.NUM_REQ(4), .B_PER_T(8)) bus1 ();

  uart_tx_arbiter #(.NUM_REQ(4), .B_PER_T(8), .MAX_BURST(4)) dut4 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus4)
  );

  uart_tx_arbiter #(.NUM_REQ(4), .B_PER_T(8), .MAX_BURST(1)) dut1 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set4(input int k, input logic [7:0] v);
    bus4.i_req_data[k*8 +: 8] = v;
  endtask

  initial begin
    logic [31:0] exp_oh;
    bus4.i_req_data  = '0;
    bus4.i_req_valid = '0;
    bus4.i_tx_done   = 1'b0;
    bus1.i_req_data  = '0;
    bus1.i_req_valid = '0;
    bus1.i_tx_done   = 1'b0;

    // Reset with every requester valid
    rst = 1'b1;
    bus4.i_req_valid = 4'hF;
    bus4.i_req_data  = 32'h13121110;
    repeat (3) step();
    chk("rst_ready", 32'(bus4.o_req_ready), 32'h0);
    chk("rst_grant", 32'(bus4.o_grant), 32'h0);
    chk("rst_data",  32'(bus4.o_tx_data), 32'h0);
    chk("rst_dv",    32'(bus4.o_tx_dv), 32'h0);
    chk("rst_busy",  32'(bus4.o_busy), 32'h0);
    rst = 1'b0;
    #1;
    chk("rel_ready", 32'(bus4.o_req_ready), 32'h1);
    step();
    chk("first_dv",    32'(bus4.o_tx_dv), 32'h1);
    chk("first_grant", 32'(bus4.o_grant), 32'h1);
    chk("first_data",  32'(bus4.o_tx_data), 32'h10);
    bus4.i_req_valid = 4'h0;
    step();
    chk("first_dv_off", 32'(bus4.o_tx_dv), 32'h0);
    step();
    bus4.i_tx_done = 1'b1;
    #1;
    chk("first_done_ready", 32'(bus4.o_req_ready), 32'h0);
    step();
    bus4.i_tx_done = 1'b0;
    chk("first_rel_grant", 32'(bus4.o_grant), 32'h0);
    chk("first_rel_busy",  32'(bus4.o_busy), 32'h0);

    // Single byte from req2, done 10 cycles after DV
    bus4.i_req_valid = 4'b0100;
    set4(2, 8'hA5);
    #1;
    chk("single_ready", 32'(bus4.o_req_ready), 32'h4);
    step();
    chk("single_dv",    32'(bus4.o_tx_dv), 32'h1);
    chk("single_data",  32'(bus4.o_tx_data), 32'hA5);
    chk("single_grant", 32'(bus4.o_grant), 32'h4);
    bus4.i_req_valid = 4'h0;
    for (int i = 0; i < 9; i++) begin
      step();
      chk("single_wait_dv",    32'(bus4.o_tx_dv), 32'h0);
      chk("single_wait_grant", 32'(bus4.o_grant), 32'h4);
    end
    bus4.i_tx_done = 1'b1;
    step();
    bus4.i_tx_done = 1'b0;
    chk("single_end_grant", 32'(bus4.o_grant), 32'h0);
    chk("single_end_busy",  32'(bus4.o_busy), 32'h0);
    chk("single_end_data",  32'(bus4.o_tx_data), 32'hA5);

    // Burst limit: req1 offers 6 bytes, req3 joins after the first accept
    bus4.i_req_valid = 4'b0010;
    set4(1, 8'h61);
    #1;
    chk("burst_ready1", 32'(bus4.o_req_ready), 32'h2);
    step();
    chk("burst_dv1",   32'(bus4.o_tx_dv), 32'h1);
    chk("burst_data1", 32'(bus4.o_tx_data), 32'h61);
    set4(1, 8'h62);
    set4(3, 8'h30);
    bus4.i_req_valid = 4'b1010;
    step();
    for (int b = 2; b <= 4; b++) begin
      step();
      bus4.i_tx_done = 1'b1;
      #1;
      chk("burst_cont_ready", 32'(bus4.o_req_ready), 32'h2);
      step();
      bus4.i_tx_done = 1'b0;
      chk("burst_cont_dv",    32'(bus4.o_tx_dv), 32'h1);
      chk("burst_cont_data",  32'(bus4.o_tx_data), 32'h60 + 32'(b));
      chk("burst_cont_grant", 32'(bus4.o_grant), 32'h2);
      set4(1, 8'(8'h61 + b));
      step();
    end
    step();
    bus4.i_tx_done = 1'b1;
    #1;
    chk("burst_limit_ready", 32'(bus4.o_req_ready), 32'h0);
    step();
    bus4.i_tx_done = 1'b0;
    chk("burst_limit_grant", 32'(bus4.o_grant), 32'h0);
    chk("burst_limit_dv",    32'(bus4.o_tx_dv), 32'h0);
    chk("burst_req3_ready",  32'(bus4.o_req_ready), 32'h8);
    step();
    chk("burst_req3_data",  32'(bus4.o_tx_data), 32'h30);
    chk("burst_req3_grant", 32'(bus4.o_grant), 32'h8);
    bus4.i_req_valid = 4'b0010;
    step();
    step();
    bus4.i_tx_done = 1'b1;
    #1;
    chk("burst_req3_done_ready", 32'(bus4.o_req_ready), 32'h0);
    step();
    bus4.i_tx_done = 1'b0;
    chk("burst_resume_ready", 32'(bus4.o_req_ready), 32'h2);
    step();
    chk("burst_resume_data",  32'(bus4.o_tx_data), 32'h65);
    chk("burst_resume_grant", 32'(bus4.o_grant), 32'h2);
    set4(1, 8'h66);
    bus4.i_tx_done = 1'b1;
    step();
    bus4.i_tx_done = 1'b0;
    chk("send_done_ignored_busy",  32'(bus4.o_busy), 32'h1);
    chk("send_done_ignored_grant", 32'(bus4.o_grant), 32'h2);
    chk("send_done_ignored_dv",    32'(bus4.o_tx_dv), 32'h0);
    step();
    bus4.i_tx_done = 1'b1;
    #1;
    chk("burst_last_ready", 32'(bus4.o_req_ready), 32'h2);
    step();
    bus4.i_tx_done = 1'b0;
    chk("burst_last_dv",   32'(bus4.o_tx_dv), 32'h1);
    chk("burst_last_data", 32'(bus4.o_tx_data), 32'h66);
    bus4.i_req_valid = 4'h0;
    step();
    step();
    bus4.i_tx_done = 1'b1;
    step();
    bus4.i_tx_done = 1'b0;
    chk("burst_final_busy", 32'(bus4.o_busy), 32'h0);

    // Early burst end: req2 sends 2 bytes then drops valid
    bus4.i_req_valid = 4'b1101;
    set4(0, 8'h0A);
    set4(2, 8'h21);
    set4(3, 8'h3A);
    #1;
    chk("early_ready", 32'(bus4.o_req_ready), 32'h4);
    step();
    chk("early_data1", 32'(bus4.o_tx_data), 32'h21);
    set4(2, 8'h22);
    step();
    step();
    bus4.i_tx_done = 1'b1;
    #1;
    chk("early_cont_ready", 32'(bus4.o_req_ready), 32'h4);
    step();
    bus4.i_tx_done = 1'b0;
    chk("early_data2", 32'(bus4.o_tx_data), 32'h22);
    bus4.i_req_valid = 4'b1001;
    step();
    step();
    bus4.i_tx_done = 1'b1;
    #1;
    chk("early_end_ready", 32'(bus4.o_req_ready), 32'h0);
    step();
    bus4.i_tx_done = 1'b0;
    chk("early_idle_busy",  32'(bus4.o_busy), 32'h0);
    chk("early_idle_grant", 32'(bus4.o_grant), 32'h0);
    chk("early_next_ready", 32'(bus4.o_req_ready), 32'h8);
    step();
    chk("early_next_grant", 32'(bus4.o_grant), 32'h8);
    chk("early_next_data",  32'(bus4.o_tx_data), 32'h3A);
    bus4.i_req_valid = 4'h0;
    step();
    step();
    bus4.i_tx_done = 1'b1;
    step();
    bus4.i_tx_done = 1'b0;

    // Reset while waiting for the frame
    bus4.i_req_valid = 4'b0010;
    set4(1, 8'h5C);
    step();
    chk("midrst_dv",    32'(bus4.o_tx_dv), 32'h1);
    chk("midrst_grant", 32'(bus4.o_grant), 32'h2);
    bus4.i_req_valid = 4'h0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_grant0", 32'(bus4.o_grant), 32'h0);
    chk("midrst_busy0",  32'(bus4.o_busy), 32'h0);
    chk("midrst_dv0",    32'(bus4.o_tx_dv), 32'h0);
    bus4.i_tx_done = 1'b1;
    step();
    bus4.i_tx_done = 1'b0;
    chk("late_done_dv",   32'(bus4.o_tx_dv), 32'h0);
    chk("late_done_busy", 32'(bus4.o_busy), 32'h0);
    step();
    chk("late_done_dv2", 32'(bus4.o_tx_dv), 32'h0);
    bus4.i_req_valid = 4'hF;
    bus4.i_req_data  = 32'h44332211;
    #1;
    chk("postrst_ready", 32'(bus4.o_req_ready), 32'h1);
    step();
    chk("postrst_grant", 32'(bus4.o_grant), 32'h1);
    chk("postrst_data",  32'(bus4.o_tx_data), 32'h11);
    bus4.i_req_valid = 4'h0;
    step();
    step();
    bus4.i_tx_done = 1'b1;
    step();
    bus4.i_tx_done = 1'b0;

    // Round-robin fairness with MAX_BURST = 1
    bus1.i_req_valid = 4'hF;
    bus1.i_req_data  = 32'hB3B2B1B0;
    for (int f = 0; f < 8; f++) begin
      exp_oh = 32'd1 << (f % 4);
      #1;
      chk("rr_ready", 32'(bus1.o_req_ready), exp_oh);
      step();
      chk("rr_grant", 32'(bus1.o_grant), exp_oh);
      chk("rr_dv",    32'(bus1.o_tx_dv), 32'h1);
      chk("rr_data",  32'(bus1.o_tx_data), 32'hB0 + 32'(f % 4));
      step();
      step();
      bus1.i_tx_done = 1'b1;
      #1;
      chk("rr_done_ready", 32'(bus1.o_req_ready), 32'h0);
      step();
      bus1.i_tx_done = 1'b0;
      chk("rr_release", 32'(bus1.o_grant), 32'h0);
    end
    bus1.i_req_valid = 4'h0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
